// File: rtl/block_matrix_loader_if.sv
// Row-major word stream feeding the block-matrix loader.
`timescale 1ns/1ps

interface block_matrix_loader_if #(
   parameter int unsigned DWIDTH = 32
) ();
   logic              s_valid;
   logic              s_ready;
   logic [DWIDTH-1:0] s_data;
   logic              s_last;

   // Host / DMA side drives beats, loader answers with ready.
   modport master (output s_valid, output s_data, output s_last, input s_ready);
   modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/block_matrix_loader.sv
// Block-matrix loader: takes a row-major stream of matrix A followed by matrix B
// (4 x int8 per word) and scatters every word into BRAM0 in block-major order.
// A occupies words [0, MATRIX_SIZE^2/4), B the same span directly above it.
`timescale 1ns/1ps

module block_matrix_loader #(
   parameter int unsigned DWIDTH      = 32,
   parameter int unsigned AWIDTH      = 13,
   parameter int unsigned MATRIX_SIZE = 128,
   parameter int unsigned BLOCK_SIZE  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_run,
   output logic                  o_idle,
   output logic                  o_load,
   output logic                  o_done,
   output logic                  o_err,
   block_matrix_loader_if.slave  stream,
   output logic [AWIDTH-1:0]     addr_b0,
   output logic                  ce_b0,
   output logic                  we_b0,
   output logic [DWIDTH-1:0]     d_b0
);

   // Geometry; every quantity is a power of two so the address is a bit shuffle.
   localparam int unsigned WPR              = MATRIX_SIZE / 4;
   localparam int unsigned ADDR_BLOCK_SIZE  = BLOCK_SIZE * BLOCK_SIZE / 4;
   localparam int unsigned MATRIX_BLOCK     = MATRIX_SIZE / BLOCK_SIZE;
   localparam int unsigned ADDR_MATRIX_SIZE = MATRIX_SIZE * MATRIX_SIZE / 4;

   localparam int unsigned CW_W  = $clog2(WPR);
   localparam int unsigned R_W   = $clog2(MATRIX_SIZE);
   localparam int unsigned CWL_W = $clog2(BLOCK_SIZE / 4);
   localparam int unsigned RL_W  = $clog2(BLOCK_SIZE);
   localparam int unsigned CWH_W = $clog2(MATRIX_BLOCK);
   localparam int unsigned ABS_W = $clog2(ADDR_BLOCK_SIZE);
   localparam int unsigned AMS_W = $clog2(ADDR_MATRIX_SIZE);

   localparam logic [CW_W-1:0]   CW_MAX   = CW_W'(WPR - 1);
   localparam logic [R_W-1:0]    R_MAX    = R_W'(MATRIX_SIZE - 1);
   localparam logic [AWIDTH-1:0] CWL_MASK = AWIDTH'(BLOCK_SIZE / 4 - 1);
   localparam logic [AWIDTH-1:0] RL_MASK  = AWIDTH'(BLOCK_SIZE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   logic [CW_W-1:0] cw;
   logic [R_W-1:0]  r;
   logic            mat;
   logic            all_acc;

   logic              xfer_c;
   logic              last_beat_c;
   logic [AWIDTH-1:0] cw_a_c;
   logic [AWIDTH-1:0] r_a_c;
   logic [AWIDTH-1:0] addr_c;

   assign o_idle = (state == S_IDLE);
   assign o_load = (state == S_RUN);
   assign o_done = (state == S_DONE);

   assign stream.s_ready = (state == S_RUN) && !all_acc;
   assign xfer_c         = stream.s_valid && stream.s_ready;
   assign last_beat_c    = mat && (r == R_MAX) && (cw == CW_MAX);

   // Block-major address: {mat | row-block | col-block | row-in-block | word-in-block-row}.
   assign cw_a_c = AWIDTH'(cw);
   assign r_a_c  = AWIDTH'(r);
   assign addr_c = (AWIDTH'(mat) << AMS_W)
                 | ((r_a_c >> RL_W) << (CWH_W + ABS_W))
                 | ((cw_a_c >> CWL_W) << ABS_W)
                 | ((r_a_c & RL_MASK) << CWL_W)
                 | (cw_a_c & CWL_MASK);

   // Control FSM, beat counters, framing check and registered BRAM write port.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cw      <= '0;
         r       <= '0;
         mat     <= 1'b0;
         all_acc <= 1'b0;
         addr_b0 <= '0;
         d_b0    <= '0;
         ce_b0   <= 1'b0;
         we_b0   <= 1'b0;
         o_err   <= 1'b0;
      end else begin
         ce_b0 <= 1'b0;
         we_b0 <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_run) begin
                  state <= S_RUN;
                  o_err <= 1'b0;
               end
            end
            S_RUN: begin
               if (xfer_c) begin
                  ce_b0   <= 1'b1;
                  we_b0   <= 1'b1;
                  addr_b0 <= addr_c;
                  d_b0    <= stream.s_data;
                  if (stream.s_last != last_beat_c) begin
                     o_err <= 1'b1;
                  end
                  if (last_beat_c) begin
                     all_acc <= 1'b1;
                  end
                  if (cw == CW_MAX) begin
                     cw <= '0;
                     if (r == R_MAX) begin
                        r   <= '0;
                        mat <= ~mat;
                     end else begin
                        r <= r + R_W'(1);
                     end
                  end else begin
                     cw <= cw + CW_W'(1);
                  end
               end
               // Final write is on the port this cycle; leave once it is issued.
               if (all_acc) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               all_acc <= 1'b0;
               state   <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_block_matrix_loader.sv
// Directed bench for block_matrix_loader with the default 128x128 / 16x16 geometry.
`timescale 1ns/1ps

module tb_block_matrix_loader;

   localparam int unsigned DW  = 32;
   localparam int unsigned AW  = 13;
   localparam int unsigned MS  = 128;
   localparam int unsigned BS  = 16;
   localparam int unsigned WPR = MS / 4;
   localparam int unsigned AMS = MS * MS / 4;
   localparam int unsigned NB  = 2 * AMS;

   logic          clk;
   logic          reset;
   logic          i_run;
   logic          o_idle;
   logic          o_load;
   logic          o_done;
   logic          o_err;
   logic [AW-1:0] addr_b0;
   logic          ce_b0;
   logic          we_b0;
   logic [DW-1:0] d_b0;

   block_matrix_loader_if #(.DWIDTH(DW)) bus ();

   block_matrix_loader #(
      .DWIDTH      (DW),
      .AWIDTH      (AW),
      .MATRIX_SIZE (MS),
      .BLOCK_SIZE  (BS)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .i_run   (i_run),
      .o_idle  (o_idle),
      .o_load  (o_load),
      .o_done  (o_done),
      .o_err   (o_err),
      .stream  (bus),
      .addr_b0 (addr_b0),
      .ce_b0   (ce_b0),
      .we_b0   (we_b0),
      .d_b0    (d_b0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp;
   int unsigned n_bad;

   // Single comparison point for the whole bench.
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference layout written straight from the block-major definition.
   function automatic int unsigned exp_addr(input int unsigned b);
      int unsigned mat, rem, r, cw;
      mat = b / AMS;
      rem = b % AMS;
      r   = rem / WPR;
      cw  = rem % WPR;
      return mat * AMS + ((r / BS) * (MS / BS) + (cw * 4) / BS) * (BS * BS / 4)
             + (r % BS) * (BS / 4) + cw % (BS / 4);
   endfunction

   // Write-port monitor: memory image, per-beat address log, latency and done tracking.
   logic [31:0] mem     [0:NB-1];
   int unsigned mem_run [0:NB-1];
   int unsigned wr_log  [0:NB-1];
   int unsigned run_id;
   int unsigned wr_cnt;
   int unsigned lat_err;
   int unsigned done_cnt;
   bit          pend;

   always @(negedge clk) begin
      if (reset) begin
         pend = 1'b0;
      end else begin
         if (we_b0 !== pend || ce_b0 !== pend) lat_err++;
         if (we_b0 === 1'b1) begin
            mem[addr_b0]     = d_b0;
            mem_run[addr_b0] = run_id;
            wr_log[int'(d_b0 % NB)] = int'(addr_b0);
            wr_cnt++;
         end
         if (o_done === 1'b1) done_cnt++;
         pend = bus.s_valid && bus.s_ready;
      end
   end

   task automatic start_run();
      i_run = 1'b1;
      @(posedge clk); #1;
      i_run = 1'b0;
   endtask

   // Offer one beat after 'gap' idle cycles; returns 1 ns after the transfer edge.
   task automatic send_beat(input int b, input bit last, input int gap, input bit pulse);
      int waited;
      bus.s_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      bus.s_valid = 1'b1;
      bus.s_data  = 32'(b);
      bus.s_last  = last;
      i_run       = pulse;
      waited      = 0;
      forever begin
         @(negedge clk);
         if (bus.s_ready) break;
         waited++;
         if (waited > 50) begin
            check_eq("ready_timeout", 32'(bus.s_ready), 32'd1);
            break;
         end
      end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      i_run       = 1'b0;
   endtask

   // One full A+B load with optional gaps, framing faults and a stray i_run.
   task automatic load_run(input int max_gap, input int bad_last_beat, input bit omit_final_last,
                           input int pulse_beat, input bit exp_err);
      int unsigned lat0, wr0, done0, bad;
      int cyc;
      bit last;
      int gap;
      run_id++;
      lat0  = lat_err;
      wr0   = wr_cnt;
      done0 = done_cnt;
      for (int b = 0; b < int'(NB); b++) begin
         last = ((b == int'(NB) - 1) && !omit_final_last) || (b == bad_last_beat);
         gap  = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         send_beat(b, last, gap, b == pulse_beat);
         if (b == bad_last_beat) check_eq("err_on_early_last", 32'(o_err), 32'd1);
         if (b == pulse_beat)    check_eq("run_pulse_ignored", 32'(o_load), 32'd1);
         if (omit_final_last && b == int'(NB) - 2) check_eq("err_before_final", 32'(o_err), 32'd0);
      end
      check_eq("final_we", 32'(we_b0), 32'd1);
      check_eq("final_ready_low", 32'(bus.s_ready), 32'd0);
      check_eq("final_still_load", 32'(o_load), 32'd1);
      cyc = 0;
      while (o_idle !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("cycles_to_idle", 32'(cyc), 32'd2);
      check_eq("done_pulses", done_cnt - done0, 32'd1);
      check_eq("write_count", wr_cnt - wr0, NB);
      check_eq("latency_violations", lat_err - lat0, 32'd0);
      check_eq("err_end_of_run", 32'(o_err), 32'(exp_err));
      bad = 0;
      for (int unsigned b = 0; b < NB; b++) begin
         if (mem[exp_addr(b)] !== b || mem_run[exp_addr(b)] != run_id) bad++;
      end
      check_eq("image_bad_words", bad, 32'd0);
   endtask

   int unsigned map_beat [9] = '{0, 3, 4, 31, 32, 512, 4095, 4096, 8191};
   int unsigned map_addr [9] = '{0, 3, 64, 451, 4, 512, 4095, 4096, 8191};

   initial begin
      #1_500_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      i_run       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      run_id      = 0;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      check_eq("rst_idle",  32'(o_idle),  32'd1);
      check_eq("rst_load",  32'(o_load),  32'd0);
      check_eq("rst_done",  32'(o_done),  32'd0);
      check_eq("rst_err",   32'(o_err),   32'd0);
      check_eq("rst_we",    32'(we_b0),   32'd0);
      check_eq("rst_ce",    32'(ce_b0),   32'd0);
      check_eq("rst_addr",  32'(addr_b0), 32'd0);
      check_eq("rst_ready", 32'(bus.s_ready), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of a run with a write pending
      start_run();
      check_eq("t1_load", 32'(o_load), 32'd1);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'h55;
      bus.s_last  = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_eq("t1_pre_we",   32'(we_b0),   32'd1);
      check_eq("t1_pre_addr", 32'(addr_b0), 32'd64);
      check_eq("t1_pre_err",  32'(o_err),   32'd1);
      reset = 1'b1;
      #1;
      check_eq("t1_we_drop", 32'(we_b0),   32'd0);
      check_eq("t1_idle",    32'(o_idle),  32'd1);
      check_eq("t1_err",     32'(o_err),   32'd0);
      check_eq("t1_addr",    32'(addr_b0), 32'd0);
      check_eq("t1_ready",   32'(bus.s_ready), 32'd0);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Full back-to-back load with a stray i_run at beat 2000, then the address map
      start_run();
      load_run(0, -1, 1'b0, 2000, 1'b0);
      for (int i = 0; i < 9; i++) begin
         check_eq($sformatf("map_beat%0d", map_beat[i]), wr_log[map_beat[i]], map_addr[i]);
      end

      // Same load with random 0-5 cycle gaps
      start_run();
      load_run(5, -1, 1'b0, -1, 1'b0);

      // Early s_last on beat 100: sticky error to the end of run
      start_run();
      load_run(0, 100, 1'b0, -1, 1'b1);
      check_eq("err_sticky_idle", 32'(o_err), 32'd1);

      // Next run clears the error; missing final s_last flags it again
      start_run();
      check_eq("err_cleared_on_run", 32'(o_err), 32'd0);
      load_run(0, -1, 1'b1, -1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
